brq_load_store_unit: RTL and testbench

BRQ_LOAD_STORE_UNIT -- requirements
Module: brq_load_store_unit

---
 rtl/brq_pkg.sv | 60 ++++++
 rtl/brq_lsu_rdata_align.sv | 41 ++++
 rtl/brq_load_store_unit.sv | 197 +++++++++++++++++++
 tb/tb_brq_load_store_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brq_pkg.sv
// brq_pkg: shared load/store unit types and helpers.
//   lsu_type_e          access size encoding (W/H/B)
//   lsu_misaligned()    access needs two bus transactions
//   lsu_be_part1/2()    byte enables for the first and second bus beats
//   lsu_rotate_wdata()  rotate LSB-aligned store data into its byte lanes
package brq_pkg;

  typedef enum logic [1:0] {
    LSU_W = 2'b00,
    LSU_H = 2'b01,
    LSU_B = 2'b10
  } lsu_type_e;

  // A word that is not word-aligned, or a halfword in the top byte lane,
  // spills into the next word.
  function automatic logic lsu_misaligned(input lsu_type_e ty, input logic [1:0] off);
    return ((ty == LSU_W) && (off != 2'b00)) || ((ty == LSU_H) && (off == 2'b11));
  endfunction

  function automatic logic [3:0] lsu_be_part1(input lsu_type_e ty, input logic [1:0] off);
    logic [3:0] be;
    unique case (ty)
      LSU_W:   be = 4'b1111 << off;
      LSU_H:   be = 4'b0011 << off;
      default: be = 4'b0001 << off;
    endcase
    return be;
  endfunction

  // Lanes of the following word touched by a misaligned access.
  function automatic logic [3:0] lsu_be_part2(input lsu_type_e ty, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    if (ty == LSU_W) begin
      unique case (off)
        2'b01:   be = 4'b0001;
        2'b10:   be = 4'b0011;
        2'b11:   be = 4'b0111;
        default: be = 4'b0000;
      endcase
    end else if ((ty == LSU_H) && (off == 2'b11)) begin
      be = 4'b0001;
    end
    return be;
  endfunction

  // Rotating (rather than shifting) puts the bytes that wrap past lane 3
  // into the low lanes, which is exactly what the second beat needs.
  function automatic logic [31:0] lsu_rotate_wdata(input logic [31:0] wdata, input logic [1:0] off);
    logic [31:0] rot;
    unique case (off)
      2'b00:   rot = wdata;
      2'b01:   rot = {wdata[23:0], wdata[31:24]};
      2'b10:   rot = {wdata[15:0], wdata[31:16]};
      default: rot = {wdata[7:0],  wdata[31:8]};
    endcase
    return rot;
  endfunction

endpackage

// File: rtl/brq_lsu_rdata_align.sv
// brq_lsu_rdata_align: combinational load data alignment and extension.
//   type_i, sign_ext_i   access size and signedness
//   off_i                byte offset of the access within its first word
//   misaligned_i         access was split into two beats
//   rdata_q_i            registered first-beat data (misaligned only)
//   rdata_i              live bus read data of the final beat
//   rdata_o              result, LSB-aligned and extended to 32 bits
module brq_lsu_rdata_align
  import brq_pkg::*;
(
  input  lsu_type_e   type_i,
  input  logic        sign_ext_i,
  input  logic [1:0]  off_i,
  input  logic        misaligned_i,
  input  logic [31:0] rdata_q_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  logic [31:0] lo_word;
  logic [31:0] shifted;

  always_comb begin
    // Single-beat accesses only ever look at the live word.
    lo_word = misaligned_i ? rdata_q_i : rdata_i;
    // Equivalent to ({rdata_i, lo_word} >> 8*off)[31:0].
    unique case (off_i)
      2'b00:   shifted = lo_word;
      2'b01:   shifted = {rdata_i[7:0],  lo_word[31:8]};
      2'b10:   shifted = {rdata_i[15:0], lo_word[31:16]};
      default: shifted = {rdata_i[23:0], lo_word[31:24]};
    endcase

    unique case (type_i)
      LSU_W:   rdata_o = shifted;
      LSU_H:   rdata_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
      default: rdata_o = {{24{sign_ext_i & shifted[7]}},  shifted[7:0]};
    endcase
  end

endmodule

// File: rtl/brq_load_store_unit.sv
// brq_load_store_unit: load/store unit between ID/EX and the data bus.
// Splits misaligned accesses into two word-aligned beats, keeps at most one
// bus transaction outstanding and assembles load results for writeback.
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   lsu_req_i .. lsu_wdata_i         request from ID/EX, held until done
//   data_req_o .. data_wdata_o       bus address phase (req/gnt handshake)
//   data_rvalid_i, data_err_i,
//   data_rdata_i                     bus response phase
//   lsu_req_done_o                   final address phase granted
//   lsu_resp_valid_o                 final response received
//   lsu_rdata_o, lsu_rdata_valid_o   load result and RF write enable
//   load_err_o, store_err_o          error pulse at completion
//   busy_o                           FSM not idle
module brq_load_store_unit
  import brq_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  lsu_type_e   lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,

  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  input  logic [31:0] data_rdata_i,

  output logic        lsu_req_done_o,
  output logic        lsu_resp_valid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_rdata_valid_o,
  output logic        load_err_o,
  output logic        store_err_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GNT_MIS,
    WAIT_RVALID_MIS,
    WAIT_GNT,
    WAIT_RVALID
  } ls_fsm_e;

  ls_fsm_e     state_q;
  logic [29:0] addr_q;       // word address of the first beat
  lsu_type_e   type_q;
  logic        sign_q;
  logic        we_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;      // already rotated into byte lanes
  logic [31:0] rdata_q;      // first-beat read data
  logic        err_q;        // sticky error across both beats

  logic        idle_req;
  logic        mis_new;
  logic        mis_q;
  logic        err_final;
  logic [31:0] rdata_aligned;

  // Gating with rst_ni keeps the bus quiet while reset is held even though
  // the IDLE address phase is combinational from the request inputs.
  assign idle_req = lsu_req_i & rst_ni;
  assign mis_new  = lsu_misaligned(lsu_type_i, lsu_addr_i[1:0]);
  assign mis_q    = lsu_misaligned(type_q, off_q);

  // Bus address phase. In WAIT_GNT a misaligned access is necessarily on its
  // second beat, so the captured size/offset alone select the beat.
  always_comb begin
    data_req_o   = 1'b0;
    data_addr_o  = 32'h0;
    data_we_o    = 1'b0;
    data_be_o    = 4'h0;
    data_wdata_o = 32'h0;
    unique case (state_q)
      IDLE: begin
        if (idle_req) begin
          data_req_o   = 1'b1;
          data_addr_o  = {lsu_addr_i[31:2], 2'b00};
          data_we_o    = lsu_we_i;
          data_be_o    = lsu_be_part1(lsu_type_i, lsu_addr_i[1:0]);
          data_wdata_o = lsu_rotate_wdata(lsu_wdata_i, lsu_addr_i[1:0]);
        end
      end
      WAIT_GNT_MIS: begin
        data_req_o   = 1'b1;
        data_addr_o  = {addr_q, 2'b00};
        data_we_o    = we_q;
        data_be_o    = lsu_be_part1(type_q, off_q);
        data_wdata_o = wdata_q;
      end
      WAIT_RVALID_MIS: begin
        // Second beat goes out in the same cycle the first one completes.
        data_req_o   = data_rvalid_i;
        data_addr_o  = {addr_q + 30'd1, 2'b00};
        data_we_o    = we_q;
        data_be_o    = lsu_be_part2(type_q, off_q);
        data_wdata_o = wdata_q;
      end
      WAIT_GNT: begin
        data_req_o   = 1'b1;
        data_addr_o  = mis_q ? {addr_q + 30'd1, 2'b00} : {addr_q, 2'b00};
        data_we_o    = we_q;
        data_be_o    = mis_q ? lsu_be_part2(type_q, off_q) : lsu_be_part1(type_q, off_q);
        data_wdata_o = wdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= 30'h0;
      type_q  <= LSU_W;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      off_q   <= 2'b00;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (lsu_req_i) begin
            addr_q  <= lsu_addr_i[31:2];
            type_q  <= lsu_type_i;
            sign_q  <= lsu_sign_ext_i;
            we_q    <= lsu_we_i;
            off_q   <= lsu_addr_i[1:0];
            wdata_q <= lsu_rotate_wdata(lsu_wdata_i, lsu_addr_i[1:0]);
            err_q   <= 1'b0;
            if (mis_new) begin
              state_q <= data_gnt_i ? WAIT_RVALID_MIS : WAIT_GNT_MIS;
            end else begin
              state_q <= data_gnt_i ? WAIT_RVALID : WAIT_GNT;
            end
          end
        end
        WAIT_GNT_MIS: begin
          if (data_gnt_i) state_q <= WAIT_RVALID_MIS;
        end
        WAIT_RVALID_MIS: begin
          if (data_rvalid_i) begin
            rdata_q <= data_rdata_i;
            err_q   <= err_q | data_err_i;
            state_q <= data_gnt_i ? WAIT_RVALID : WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (data_gnt_i) state_q <= WAIT_RVALID;
        end
        WAIT_RVALID: begin
          if (data_rvalid_i) begin
            err_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  brq_lsu_rdata_align u_rdata_align (
    .type_i       (type_q),
    .sign_ext_i   (sign_q),
    .off_i        (off_q),
    .misaligned_i (mis_q),
    .rdata_q_i    (rdata_q),
    .rdata_i      (data_rdata_i),
    .rdata_o      (rdata_aligned)
  );

  // Only the grant of the last beat lets ID/EX move on.
  assign lsu_req_done_o = data_gnt_i &
                          (((state_q == IDLE) & idle_req & ~mis_new) |
                           (state_q == WAIT_GNT) |
                           ((state_q == WAIT_RVALID_MIS) & data_rvalid_i));

  assign lsu_resp_valid_o  = (state_q == WAIT_RVALID) & data_rvalid_i;
  assign err_final         = err_q | data_err_i;
  assign lsu_rdata_o       = lsu_resp_valid_o ? rdata_aligned : 32'h0;
  assign lsu_rdata_valid_o = lsu_resp_valid_o & ~we_q & ~err_final;
  assign load_err_o        = lsu_resp_valid_o & ~we_q & err_final;
  assign store_err_o       = lsu_resp_valid_o & we_q & err_final;
  assign busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_brq_load_store_unit.sv
module tb_brq_load_store_unit;
  import brq_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        lsu_req_i;
  logic        lsu_we_i;
  lsu_type_e   lsu_type_i;
  logic        lsu_sign_ext_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        data_req_o;
  logic        data_gnt_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic        data_err_i;
  logic [31:0] data_rdata_i;
  logic        lsu_req_done_o;
  logic        lsu_resp_valid_o;
  logic [31:0] lsu_rdata_o;
  logic        lsu_rdata_valid_o;
  logic        load_err_o;
  logic        store_err_o;
  logic        busy_o;

  typedef struct {
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        rdata_valid;
    logic        load_err;
    logic        store_err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   resp_pulses = 0;

  always #5 clk_i = ~clk_i;

  brq_load_store_unit dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .lsu_req_i         (lsu_req_i),
    .lsu_we_i          (lsu_we_i),
    .lsu_type_i        (lsu_type_i),
    .lsu_sign_ext_i    (lsu_sign_ext_i),
    .lsu_addr_i        (lsu_addr_i),
    .lsu_wdata_i       (lsu_wdata_i),
    .data_req_o        (data_req_o),
    .data_gnt_i        (data_gnt_i),
    .data_addr_o       (data_addr_o),
    .data_we_o         (data_we_o),
    .data_be_o         (data_be_o),
    .data_wdata_o      (data_wdata_o),
    .data_rvalid_i     (data_rvalid_i),
    .data_err_i        (data_err_i),
    .data_rdata_i      (data_rdata_i),
    .lsu_req_done_o    (lsu_req_done_o),
    .lsu_resp_valid_o  (lsu_resp_valid_o),
    .lsu_rdata_o       (lsu_rdata_o),
    .lsu_rdata_valid_o (lsu_rdata_valid_o),
    .load_err_o        (load_err_o),
    .store_err_o       (store_err_o),
    .busy_o            (busy_o)
  );

  always @(posedge clk_i) begin
    if (lsu_resp_valid_o === 1'b1) resp_pulses <= resp_pulses + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access, starting and ending at a falling edge. Grant of the
  // first beat is withheld gnt_wait cycles (with stray responses meanwhile);
  // a second beat, if any, is granted immediately.
  task automatic run_access(
    input string       tag,
    input logic        we,
    input lsu_type_e   ty,
    input logic        sx,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input int          gnt_wait,
    input logic [31:0] rd1,
    input logic        e1,
    input logic [31:0] rd2,
    input logic        e2,
    input logic [31:0] exp_a1,
    input logic [3:0]  exp_be1,
    input logic [3:0]  exp_be2,
    input logic [31:0] exp_wd,
    input logic        mis,
    input logic [31:0] exp_rdata,
    input logic        exp_err
  );
    exp_t e;
    exp_t got;
    int   pulses0;
    pulses0       = resp_pulses;
    e.rdata       = exp_rdata;
    e.chk_rdata   = !we && !exp_err;
    e.rdata_valid = !we && !exp_err;
    e.load_err    = !we && exp_err;
    e.store_err   = we && exp_err;
    sb_q.push_back(e);

    lsu_req_i      = 1'b1;
    lsu_we_i       = we;
    lsu_type_i     = ty;
    lsu_sign_ext_i = sx;
    lsu_addr_i     = addr;
    lsu_wdata_i    = wdata;
    for (int w = 0; w <= gnt_wait; w++) begin
      data_gnt_i    = (w == gnt_wait);
      data_rvalid_i = (w != gnt_wait);
      data_err_i    = (w != gnt_wait);
      data_rdata_i  = 32'hBAD0_0000;
      #1;
      chk($sformatf("%s.p1.req", tag), data_req_o, 1'b1);
      chk($sformatf("%s.p1.addr", tag), data_addr_o, exp_a1);
      chk($sformatf("%s.p1.be", tag), data_be_o, exp_be1);
      chk($sformatf("%s.p1.we", tag), data_we_o, we);
      chk($sformatf("%s.p1.wdata", tag), data_wdata_o, exp_wd);
      chk($sformatf("%s.p1.done", tag), lsu_req_done_o, (w == gnt_wait) && !mis);
      chk($sformatf("%s.p1.resp", tag), lsu_resp_valid_o, 1'b0);
      @(negedge clk_i);
    end
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
    if (!mis) lsu_req_i = 1'b0;

    if (mis) begin
      data_rvalid_i = 1'b1;
      data_rdata_i  = rd1;
      data_err_i    = e1;
      data_gnt_i    = 1'b1;
      #1;
      chk($sformatf("%s.p2.req", tag), data_req_o, 1'b1);
      chk($sformatf("%s.p2.addr", tag), data_addr_o, exp_a1 + 32'd4);
      chk($sformatf("%s.p2.be", tag), data_be_o, exp_be2);
      chk($sformatf("%s.p2.we", tag), data_we_o, we);
      chk($sformatf("%s.p2.wdata", tag), data_wdata_o, exp_wd);
      chk($sformatf("%s.p2.done", tag), lsu_req_done_o, 1'b1);
      chk($sformatf("%s.p2.resp", tag), lsu_resp_valid_o, 1'b0);
      @(negedge clk_i);
      lsu_req_i  = 1'b0;
      data_gnt_i = 1'b0;
    end

    data_rvalid_i = 1'b1;
    data_rdata_i  = mis ? rd2 : rd1;
    data_err_i    = mis ? e2 : e1;
    #1;
    chk($sformatf("%s.fin.resp", tag), lsu_resp_valid_o, 1'b1);
    chk($sformatf("%s.fin.req", tag), data_req_o, 1'b0);
    if (lsu_resp_valid_o === 1'b1 && sb_q.size() > 0) begin
      got = sb_q.pop_front();
      if (got.chk_rdata) chk($sformatf("%s.rdata", tag), lsu_rdata_o, got.rdata);
      chk($sformatf("%s.rdata_valid", tag), lsu_rdata_valid_o, got.rdata_valid);
      chk($sformatf("%s.load_err", tag), load_err_o, got.load_err);
      chk($sformatf("%s.store_err", tag), store_err_o, got.store_err);
    end
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
    data_rdata_i  = 32'h0;
    chk($sformatf("%s.pulses", tag), resp_pulses - pulses0, 1);
    $display("access %s: we=%0b addr=%h resp_pulses=%0d", tag, we, addr, resp_pulses - pulses0);
  endtask

  initial begin
    int pulses0;
    rst_ni         = 1'b0;
    lsu_req_i      = 1'b1;
    lsu_we_i       = 1'b1;
    lsu_type_i     = LSU_W;
    lsu_sign_ext_i = 1'b0;
    lsu_addr_i     = 32'h0000_1234;
    lsu_wdata_i    = 32'hFFFF_FFFF;
    data_gnt_i     = 1'b1;
    data_rvalid_i  = 1'b1;
    data_err_i     = 1'b1;
    data_rdata_i   = 32'hFFFF_FFFF;

    // Outputs must be quiet while reset is held, whatever the inputs do.
    #2;
    chk("rst.req", data_req_o, 1'b0);
    chk("rst.addr", data_addr_o, 32'h0);
    chk("rst.be", data_be_o, 4'h0);
    chk("rst.wdata", data_wdata_o, 32'h0);
    chk("rst.done", lsu_req_done_o, 1'b0);
    chk("rst.resp", lsu_resp_valid_o, 1'b0);
    chk("rst.errs", {load_err_o, store_err_o, lsu_rdata_valid_o}, 3'b000);
    chk("rst.busy", busy_o, 1'b0);
    lsu_req_i     = 1'b0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("post_rst.busy", busy_o, 1'b0);
    chk("post_rst.req", data_req_o, 1'b0);
    @(negedge clk_i);

    //          tag      we    type   sx    addr          wdata         gw rd1           e1    rd2           e2    a1            be1      be2      exp_wd        mis   exp_rdata     err
    run_access("lw",    1'b0, LSU_W, 1'b0, 32'h0000_0100, 32'h0,        0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 32'h0000_0100, 4'b1111, 4'b0000, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0);
    run_access("lb_s",  1'b0, LSU_B, 1'b1, 32'h0000_0203, 32'h0,        0, 32'h80112233, 1'b0, 32'h0,        1'b0, 32'h0000_0200, 4'b1000, 4'b0000, 32'h0,        1'b0, 32'hFFFFFF80, 1'b0);
    run_access("sw_mis",1'b1, LSU_W, 1'b0, 32'h0000_0301, 32'h11223344, 1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0000_0300, 4'b1110, 4'b0001, 32'h22334411, 1'b1, 32'h0,        1'b0);
    run_access("lh_mis",1'b0, LSU_H, 1'b0, 32'h0000_0403, 32'h0,        0, 32'hAB000000, 1'b0, 32'h000000CD, 1'b0, 32'h0000_0400, 4'b1000, 4'b0001, 32'h0,        1'b1, 32'h0000CDAB, 1'b0);
    run_access("lw_err",1'b0, LSU_W, 1'b0, 32'h0000_0602, 32'h0,        0, 32'h12345678, 1'b1, 32'h9ABCDEF0, 1'b0, 32'h0000_0600, 4'b1100, 4'b0011, 32'h0,        1'b1, 32'h0,        1'b1);
    run_access("sh",    1'b1, LSU_H, 1'b0, 32'h0000_0702, 32'h0000BEEF, 2, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0000_0700, 4'b1100, 4'b0000, 32'hBEEF0000, 1'b0, 32'h0,        1'b0);
    run_access("lh_s",  1'b0, LSU_H, 1'b1, 32'h0000_0801, 32'h0,        0, 32'h00F00100, 1'b0, 32'h0,        1'b0, 32'h0000_0800, 4'b0110, 4'b0000, 32'h0,        1'b0, 32'hFFFFF001, 1'b0);
    run_access("lb_u",  1'b0, LSU_B, 1'b0, 32'h0000_0902, 32'h0,        1, 32'h00C30000, 1'b0, 32'h0,        1'b0, 32'h0000_0900, 4'b0100, 4'b0000, 32'h0,        1'b0, 32'h000000C3, 1'b0);
    run_access("sb_err",1'b1, LSU_B, 1'b0, 32'h0000_0A03, 32'h000000AB, 0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0000_0A00, 4'b1000, 4'b0000, 32'hAB000000, 1'b0, 32'h0,        1'b1);
    run_access("lw_mis",1'b0, LSU_W, 1'b0, 32'h0000_0B03, 32'h0,        2, 32'h44000000, 1'b0, 32'h00112233, 1'b0, 32'h0000_0B00, 4'b1000, 4'b0111, 32'h0,        1'b1, 32'h11223344, 1'b0);

    // Grant withheld three cycles, then reset lands in WAIT_RVALID.
    pulses0        = resp_pulses;
    lsu_req_i      = 1'b1;
    lsu_we_i       = 1'b0;
    lsu_type_i     = LSU_W;
    lsu_sign_ext_i = 1'b0;
    lsu_addr_i     = 32'h0000_0500;
    lsu_wdata_i    = 32'h0;
    for (int w = 0; w <= 3; w++) begin
      data_gnt_i = (w == 3);
      #1;
      chk($sformatf("abort.req%0d", w), data_req_o, 1'b1);
      chk($sformatf("abort.addr%0d", w), data_addr_o, 32'h0000_0500);
      chk($sformatf("abort.be%0d", w), data_be_o, 4'b1111);
      chk($sformatf("abort.done%0d", w), lsu_req_done_o, w == 3);
      @(negedge clk_i);
    end
    data_gnt_i = 1'b0;
    lsu_req_i  = 1'b0;
    #1;
    chk("abort.busy_before", busy_o, 1'b1);
    rst_ni    = 1'b0;
    lsu_req_i = 1'b1;
    #1;
    chk("abort.busy_in_rst", busy_o, 1'b0);
    chk("abort.req_in_rst", data_req_o, 1'b0);
    @(negedge clk_i);
    rst_ni        = 1'b1;
    lsu_req_i     = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h5555_5555;
    #1;
    chk("abort.stray_resp", lsu_resp_valid_o, 1'b0);
    chk("abort.busy_after", busy_o, 1'b0);
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    chk("abort.pulses", resp_pulses - pulses0, 0);
    $display("access abort: reset in WAIT_RVALID, resp_pulses=%0d", resp_pulses - pulses0);

    run_access("lb_rec",1'b0, LSU_B, 1'b1, 32'h0000_0C00, 32'h0,        0, 32'h000000FE, 1'b0, 32'h0,        1'b0, 32'h0000_0C00, 4'b0001, 4'b0000, 32'h0,        1'b0, 32'hFFFFFFFE, 1'b0);

    chk("sb.empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
